// File: rtl/snax_tcdm_stream_reader.sv
// snax_tcdm_stream_reader: turns a strided read job (base, stride, len) into narrow TCDM
// read requests and streams the fixed-latency responses out over a valid/ready data port.
// Latency: a word shows up on data_o RspLatency+1 cycles after its request handshake.
// Backpressure: requests are credit-limited by free FIFO space, so data_ready_i low never drops data.
// Ports: cfg_* job descriptor (accepted in IDLE), busy_o/done_o status, tcdm_q_* request
//        channel, tcdm_p_data_i response (no handshake), data_* output stream,
//        stall_cycles_o request stall count.
// Optional: define SNAX_READER_STALL_CNT_EN to build the stall counter; otherwise it reads 0.

// snax_tcdm_stream_reader_fifo: first-word fall-through response buffer.
// Latency: a push is visible at head/!empty on the next cycle.
// Backpressure: push while full is dropped (the caller's credit scheme keeps that from happening).
module snax_tcdm_stream_reader_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CntW-1:0]  count
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_incr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CntW'(Depth));
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_incr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_incr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CntW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CntW'(1);
            end
        end
    end
endmodule

module snax_tcdm_stream_reader #(
    parameter int AddrWidth  = 48,
    parameter int DataWidth  = 32,
    parameter int LenWidth   = 16,
    parameter int RspLatency = 2,  // >= 1
    parameter int FifoDepth  = 4   // >= RspLatency
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [AddrWidth-1:0]   cfg_base_i,
    input  logic [AddrWidth-1:0]   cfg_stride_i,
    input  logic [LenWidth-1:0]    cfg_len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   tcdm_q_valid_o,
    input  logic                   tcdm_q_ready_i,
    output logic [AddrWidth-1:0]   tcdm_q_addr_o,
    output logic                   tcdm_q_write_o,
    output logic [DataWidth/8-1:0] tcdm_q_strb_o,
    input  logic [DataWidth-1:0]   tcdm_p_data_i,
    output logic                   data_valid_o,
    input  logic                   data_ready_i,
    output logic [DataWidth-1:0]   data_o,
    output logic [31:0]            stall_cycles_o
);
    localparam int FifoCntW = $clog2(FifoDepth + 1);
    localparam int InflW    = $clog2(RspLatency + 1);
    localparam int CreditW  = $clog2(2 * FifoDepth + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                state;
    state_e                state_next;
    logic                  done_next;
    logic [AddrWidth-1:0]  addr;
    logic [AddrWidth-1:0]  stride;
    logic [LenWidth-1:0]   len;
    logic [LenWidth-1:0]   issued;
    logic [RspLatency-1:0] inflight_sr;
    logic [InflW-1:0]      inflight;
    logic [FifoCntW-1:0]   fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  credit_ok;
    logic                  last_issue;
    logic                  cfg_hs;
    logic                  q_hs;
    logic                  capture;
    logic                  pop;

    // Every word issued but not yet popped holds one FIFO slot, so the FIFO cannot overflow.
    assign credit_ok  = (CreditW'(inflight) + CreditW'(fifo_count)) < CreditW'(FifoDepth);
    assign last_issue = (issued == len - LenWidth'(1));
    assign cfg_hs     = cfg_valid_i && cfg_ready_o;
    assign q_hs       = tcdm_q_valid_o && tcdm_q_ready_i;
    assign capture    = inflight_sr[RspLatency-1];
    assign pop        = data_valid_o && data_ready_i;

    assign tcdm_q_addr_o  = addr;
    assign tcdm_q_write_o = 1'b0;
    assign tcdm_q_strb_o  = '1;
    assign data_valid_o   = !fifo_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            done_o <= 1'b0;
        end else begin
            state  <= state_next;
            done_o <= done_next;
        end
    end

    always_comb begin
        state_next     = state;
        done_next      = 1'b0;
        cfg_ready_o    = 1'b0;
        busy_o         = 1'b0;
        tcdm_q_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    if (cfg_len_i == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                busy_o         = 1'b1;
                tcdm_q_valid_o = credit_ok;
                // Handshake expressed from its inputs to keep valid out of its own fan-in.
                if (credit_ok && tcdm_q_ready_i && last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (inflight == '0 && fifo_empty) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address accumulator; it only moves on a handshake, so it is stable while a request waits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr        <= '0;
            stride      <= '0;
            len         <= '0;
            issued      <= '0;
            inflight_sr <= '0;
            inflight    <= '0;
        end else begin
            if (cfg_hs) begin
                addr   <= cfg_base_i;
                stride <= cfg_stride_i;
                len    <= cfg_len_i;
                issued <= '0;
            end else if (q_hs) begin
                addr   <= addr + stride;
                issued <= issued + LenWidth'(1);
            end
            // One flag per accepted request; it reaches the top bit when the bank drives the data.
            inflight_sr <= (inflight_sr << 1) | RspLatency'(q_hs);
            if (q_hs && !capture) begin
                inflight <= inflight + InflW'(1);
            end else if (capture && !q_hs) begin
                inflight <= inflight - InflW'(1);
            end
        end
    end

    snax_tcdm_stream_reader_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth),
        .CntW  (FifoCntW)
    ) i_rsp_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (capture),
        .push_data (tcdm_p_data_i),
        .pop       (pop),
        .head      (data_o),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Unreachable while the credit accounting is correct.
    assert property (@(posedge clk_i) disable iff (rst_i) !(capture && fifo_full));

`ifdef SNAX_READER_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || cfg_hs) begin
            stall_cnt <= '0;
        end else if (tcdm_q_valid_o && !tcdm_q_ready_i && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt;
`else
    assign stall_cycles_o = '0;
`endif
endmodule

// File: tb/tb_snax_tcdm_stream_reader.sv
module tb_snax_tcdm_stream_reader;
    localparam int AW    = 48;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [AW-1:0] cfg_base_i;
    logic [AW-1:0] cfg_stride_i;
    logic [LW-1:0] cfg_len_i;
    logic          busy_o;
    logic          done_o;
    logic          tcdm_q_valid_o;
    logic          tcdm_q_ready_i;
    logic [AW-1:0] tcdm_q_addr_o;
    logic          tcdm_q_write_o;
    logic [DW/8-1:0] tcdm_q_strb_o;
    logic [DW-1:0] tcdm_p_data_i;
    logic          data_valid_o;
    logic          data_ready_i;
    logic [DW-1:0] data_o;
    logic [31:0]   stall_cycles_o;

    always #5 clk_i = ~clk_i;

    snax_tcdm_stream_reader dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .cfg_base_i     (cfg_base_i),
        .cfg_stride_i   (cfg_stride_i),
        .cfg_len_i      (cfg_len_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .tcdm_q_valid_o (tcdm_q_valid_o),
        .tcdm_q_ready_i (tcdm_q_ready_i),
        .tcdm_q_addr_o  (tcdm_q_addr_o),
        .tcdm_q_write_o (tcdm_q_write_o),
        .tcdm_q_strb_o  (tcdm_q_strb_o),
        .tcdm_p_data_i  (tcdm_p_data_i),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready_i),
        .data_o         (data_o),
        .stall_cycles_o (stall_cycles_o)
    );

    typedef struct { longint due; logic [DW-1:0] d; } bank_t;
    typedef struct { longint vis; logic [DW-1:0] d; } exp_t;

    int      n_vec = 0;
    int      n_err = 0;
    longint  cyc = 0;
    int      qr_mode;  // 0 always 1, 1 always 0, 2 random, 3 driven by hand
    int      dr_mode;  // 0 always 1, 1 always 0, 2 random

    bank_t         bq[$];
    exp_t          expq[$];
    logic [AW-1:0] hs_addr[$];
    longint        hs_cyc[$];
    logic [DW-1:0] out_dat[$];
    longint        out_cyc[$];
    int            done_cnt = 0;

    // reference model state
    logic          m_active;
    int            m_issued;
    int            m_len;
    int            m_out;
    logic [AW-1:0] m_base;
    logic [AW-1:0] m_stride;
    logic          m_done;
    longint        m_stall;
    logic [AW-1:0] ea;
    logic          ev;
    logic          edv;
    logic          dn;
    exp_t          ne;

    function automatic logic [DW-1:0] bank_word(input logic [AW-1:0] a);
        return a[31:0] ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Per-cycle comparison against a transaction-level model.
    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            m_active = 1'b0; m_issued = 0; m_len = 0; m_out = 0;
            m_done = 1'b0; m_stall = 0;
            expq.delete();
        end else begin
            ev  = m_active && (m_issued < m_len) && (m_out < DEPTH);
            ea  = m_base + AW'(m_issued) * m_stride;
            edv = (expq.size() > 0) && (expq[0].vis <= cyc);
            chk("cfg_ready", cfg_ready_o, !m_active);
            chk("busy", busy_o, m_active);
            chk("done", done_o, m_done);
            chk("q_valid", tcdm_q_valid_o, ev);
            chk("q_write", tcdm_q_write_o, 0);
            chk("q_strb", tcdm_q_strb_o, 4'hF);
            chk("data_valid", data_valid_o, edv);
`ifdef SNAX_READER_STALL_CNT_EN
            chk("stall_cycles", stall_cycles_o, m_stall);
`else
            chk("stall_cycles", stall_cycles_o, 0);
`endif
            if (ev) chk("q_addr", tcdm_q_addr_o, ea);
            if (edv) chk("data", data_o, expq[0].d);

            if (tcdm_q_valid_o && tcdm_q_ready_i) begin
                hs_addr.push_back(tcdm_q_addr_o);
                hs_cyc.push_back(cyc);
            end
            if (data_valid_o && data_ready_i) begin
                out_dat.push_back(data_o);
                out_cyc.push_back(cyc);
            end
            if (done_o) done_cnt++;

            dn = 1'b0;
            if (!m_active && cfg_valid_i) begin
                m_stall = 0;
                if (cfg_len_i == '0) begin
                    dn = 1'b1;
                end else begin
                    m_active = 1'b1; m_issued = 0; m_len = int'(cfg_len_i);
                    m_base = cfg_base_i; m_stride = cfg_stride_i;
                end
            end else if (m_active && m_issued == m_len && m_out == 0) begin
                m_active = 1'b0;
                dn = 1'b1;
            end
            if (ev && tcdm_q_ready_i) begin
                ne.vis = cyc + 3;
                ne.d = bank_word(ea);
                expq.push_back(ne);
                m_issued++;
                m_out++;
            end
            if (edv && data_ready_i) begin
                void'(expq.pop_front());
                m_out--;
            end
            if (ev && !tcdm_q_ready_i && m_stall < 64'hFFFF_FFFF) m_stall++;
            m_done = dn;
        end
    end

    // One clock of stimulus: the bank answers RspLatency cycles after each handshake.
    task automatic step();
        @(negedge clk_i);
        if (tcdm_q_valid_o && tcdm_q_ready_i) begin
            bank_t b;
            b.due = cyc + 2;
            b.d = bank_word(tcdm_q_addr_o);
            bq.push_back(b);
        end
        @(posedge clk_i);
        #1;
        while (bq.size() > 0 && bq[0].due < cyc) void'(bq.pop_front());
        if (bq.size() > 0 && bq[0].due == cyc) begin
            tcdm_p_data_i = bq[0].d;
            void'(bq.pop_front());
        end else begin
            tcdm_p_data_i = $urandom;
        end
        case (qr_mode)
            0: tcdm_q_ready_i = 1'b1;
            1: tcdm_q_ready_i = 1'b0;
            2: tcdm_q_ready_i = 1'($urandom_range(0, 1));
            default: ;
        endcase
        case (dr_mode)
            0: data_ready_i = 1'b1;
            1: data_ready_i = 1'b0;
            default: data_ready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic set_modes(input int q, input int d);
        qr_mode = q;
        dr_mode = d;
        if (q == 0) tcdm_q_ready_i = 1'b1;
        else if (q == 1) tcdm_q_ready_i = 1'b0;
        if (d == 0) data_ready_i = 1'b1;
        else if (d == 1) data_ready_i = 1'b0;
    endtask

    task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [LW-1:0] l);
        int t = 0;
        while (!cfg_ready_o && t < 300) begin
            step();
            t++;
        end
        chk("cfg_ready_wait", cfg_ready_o, 1);
        cfg_base_i = b; cfg_stride_i = s; cfg_len_i = l; cfg_valid_i = 1'b1;
        step();
        cfg_valid_i = 1'b0;
        cfg_base_i = AW'({$urandom, $urandom});
        cfg_stride_i = AW'({$urandom, $urandom});
        cfg_len_i = LW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int t = 0;
        while (!done_o && t < budget) begin
            step();
            t++;
        end
        chk("done_within_budget", done_o, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, o0, d0, t;
        logic [AW-1:0] t1a [4];
        t1a = '{48'h100, 48'h104, 48'h108, 48'h10C};

        rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_base_i = '0; cfg_stride_i = '0; cfg_len_i = '0;
        tcdm_q_ready_i = 1'b0; data_ready_i = 1'b0; tcdm_p_data_i = '0;
        set_modes(0, 0);
        repeat (3) step();
        rst_i = 1'b0;
        chk("rst_cfg_ready", cfg_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_q_valid", tcdm_q_valid_o, 0);
        chk("rst_q_addr", tcdm_q_addr_o, 0);
        chk("rst_data_valid", data_valid_o, 0);
        chk("rst_data", data_o, 0);
        step();

        // Basic job, no backpressure
        h0 = hs_addr.size(); o0 = out_dat.size(); d0 = done_cnt;
        start_job(48'h100, 48'h4, 16'd4);
        wait_done(100);
        step();
        chk("t1_num_req", hs_addr.size() - h0, 4);
        for (int k = 0; k < 4; k++) chk("t1_addr", hs_addr[h0 + k], t1a[k]);
        chk("t1_back_to_back", hs_cyc[h0 + 3] - hs_cyc[h0], 3);
        chk("t1_first_data_latency", out_cyc[o0] - hs_cyc[h0], 3);
        chk("t1_num_out", out_dat.size() - o0, 4);
        chk("t1_word0", out_dat[o0], 32'h5A5A_5B5A);
        chk("t1_word3", out_dat[o0 + 3], 32'h5A5A_5B56);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_done_low_after", done_o, 0);

        // Consumer stalled: credits cap outstanding words at the FIFO depth
        set_modes(0, 1);
        h0 = hs_addr.size(); d0 = done_cnt;
        start_job(48'h100, 48'h4, 16'd4);
        repeat (10) step();
        chk("t2a_num_req", hs_addr.size() - h0, 4);
        chk("t2a_no_done", done_cnt - d0, 0);
        chk("t2a_full_valid", data_valid_o, 1);
        set_modes(0, 0);
        wait_done(50);
        step();
        set_modes(0, 1);
        h0 = hs_addr.size(); o0 = out_dat.size();
        start_job(48'h100, 48'h4, 16'd6);
        repeat (12) step();
        chk("t2b_credit_limit", hs_addr.size() - h0, 4);
        chk("t2b_q_valid_held", tcdm_q_valid_o, 0);
        chk("t2b_busy", busy_o, 1);
        set_modes(0, 0);
        wait_done(100);
        step();
        chk("t2b_num_out", out_dat.size() - o0, 6);
        chk("t2b_word5", out_dat[o0 + 5], 32'h5A5A_5B4E);

        // Request stalls: ready 1,0,0,1
        set_modes(3, 0);
        tcdm_q_ready_i = 1'b0;
        h0 = hs_addr.size();
        start_job(48'h200, 48'h4, 16'd3);
        tcdm_q_ready_i = 1'b1; step();
        tcdm_q_ready_i = 1'b0; step(); step();
        tcdm_q_ready_i = 1'b1; step(); step();
        wait_done(50);
        chk("t3_addr0", hs_addr[h0], 48'h200);
        chk("t3_addr1", hs_addr[h0 + 1], 48'h204);
        chk("t3_addr2", hs_addr[h0 + 2], 48'h208);
        chk("t3_stall_gap", hs_cyc[h0 + 1] - hs_cyc[h0], 3);
`ifdef SNAX_READER_STALL_CNT_EN
        chk("t3_stall_cycles", stall_cycles_o, 2);
`else
        chk("t3_stall_cycles", stall_cycles_o, 0);
`endif
        step();

        // Empty job
        set_modes(0, 0);
        h0 = hs_addr.size(); d0 = done_cnt;
        start_job(48'h500, 48'h4, 16'd0);
        chk("t4_done", done_o, 1);
        chk("t4_cfg_ready", cfg_ready_o, 1);
        chk("t4_busy", busy_o, 0);
        step();
        chk("t4_done_pulse", done_o, 0);
        chk("t4_no_request", hs_addr.size() - h0, 0);
        chk("t4_done_count", done_cnt - d0, 1);

        // Address wrap
        h0 = hs_addr.size();
        start_job(48'hFFFF_FFFF_FFF8, 48'h8, 16'd2);
        wait_done(50);
        step();
        chk("t5_addr0", hs_addr[h0], 48'hFFFF_FFFF_FFF8);
        chk("t5_addr1", hs_addr[h0 + 1], 48'h0);

        // Reset mid-job
        h0 = hs_addr.size();
        start_job(48'h300, 48'h4, 16'd8);
        t = 0;
        while (hs_addr.size() - h0 < 2 && t < 50) begin
            step();
            t++;
        end
        chk("t6_two_requests", hs_addr.size() - h0, 2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("t6_cfg_ready", cfg_ready_o, 1);
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_q_valid", tcdm_q_valid_o, 0);
        chk("t6_q_addr", tcdm_q_addr_o, 0);
        chk("t6_data_valid", data_valid_o, 0);
        chk("t6_data", data_o, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_late_data_ignored", data_valid_o, 0);
        end
        o0 = out_dat.size();
        start_job(48'h400, 48'h4, 16'd3);
        wait_done(50);
        step();
        chk("t6_new_job_words", out_dat.size() - o0, 3);
        chk("t6_new_job_word0", out_dat[o0], 32'h5A5A_5E5A);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            logic [AW-1:0] b, s;
            b = AW'({$urandom, $urandom});
            s = (j % 3 == 0) ? AW'({$urandom, $urandom}) : AW'($urandom_range(0, 16));
            set_modes(($urandom_range(0, 1) == 0) ? 0 : 2, ($urandom_range(0, 1) == 0) ? 0 : 2);
            start_job(b, s, LW'($urandom_range(0, 12)));
            wait_done(600);
        end
        set_modes(0, 0);
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/snax_tcdm_stream_reader.md
Name: snax_tcdm_stream_reader

Overview:
Requester-side counterpart to the local-memory bank responder. It takes a strided read job (base, stride, length) and issues narrow read requests on one TCDM valid-ready request channel. It captures the fixed-latency response data, which carries no valid or ready signal, and streams the words out over a valid-ready data port. It sits between a SNAX accelerator's data-streamer and one memory bank port, and uses credit-based flow control so that response data is never dropped.

Parameters:
AddrWidth, 48, width of TCDM request address and configuration base/stride.
DataWidth, 32, width of one word (narrow bank width).
LenWidth, 16, width of the job length counter (words).
RspLatency, 2, cycles from request handshake to valid response data (1 SRAM cycle plus 1 pipeline register); must be at least 1.
FifoDepth, 4, response buffer depth in words; must be at least RspLatency.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_valid_i  in  1  job descriptor valid
cfg_ready_o  out  1  reader idle and accepting a descriptor
cfg_base_i  in  AddrWidth  byte address of the first word
cfg_stride_i  in  AddrWidth  byte increment between words (unsigned, wraps)
cfg_len_i  in  LenWidth  number of words to read; 0 is a legal empty job
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse when a job completes
tcdm_q_valid_o  out  1  request valid
tcdm_q_ready_i  in  1  request accepted by bank/AMO shim
tcdm_q_addr_o  out  AddrWidth  request address
tcdm_q_write_o  out  1  constant 0 (read only)
tcdm_q_strb_o  out  DataWidth/8  constant all-ones
tcdm_p_data_i  in  DataWidth  response data, valid exactly RspLatency cycles after handshake
data_valid_o  out  1  output word valid
data_ready_i  in  1  consumer accepts word
data_o  out  DataWidth  output word (FIFO head)
stall_cycles_o  out  32  request stall counter (see Optional Feature)

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high on rst_i.
- Reset values: state=IDLE, cfg_ready_o=1, busy_o=0, done_o=0, tcdm_q_valid_o=0, tcdm_q_addr_o=0, data_valid_o=0, data_o=0. All counters, the in-flight shift register and the FIFO are cleared.
- A reset asserted mid-job aborts the job. Responses still arriving from the bank afterwards are ignored, because the in-flight flags are cleared.
- FSM states:
  - IDLE: cfg_ready_o=1. On cfg_valid_i, latch base, stride and len.
    - If len==0: assert done_o on the next cycle and remain in IDLE.
    - Otherwise go to ISSUE.
  - ISSUE: tcdm_q_addr_o = base + issued*stride, computed modulo 2^AddrWidth by an incrementing accumulator (no multiplier).
    - tcdm_q_valid_o = (inflight + fifo_count) < FifoDepth.
    - Handshake when q_valid && q_ready. On handshake, issued++ and addr += stride.
    - Once valid is raised, addr must stay stable until the handshake.
    - On handshake of the word where issued == len-1, go to DRAIN.
  - DRAIN: tcdm_q_valid_o=0. When inflight==0 and the FIFO is empty, pulse done_o for 1 cycle and go to IDLE.
- busy_o=1 in ISSUE and DRAIN.
- Response capture: a RspLatency-deep shift register carries a flag per handshake. When the flag exits, tcdm_p_data_i is pushed into the FIFO.
- inflight = popcount of the shift register, kept as a counter: +1 on handshake, -1 on capture, both in the same cycle gives net 0.
- Credit rule guarantees the FIFO never overflows. The FIFO asserting full on a capture is an assertion failure.
- FIFO: first-word fall-through. data_valid_o = !empty. Pop on data_valid_o && data_ready_i. Simultaneous push and pop leaves count unchanged, and a push into an empty FIFO is visible as data_valid_o on the next cycle.
- Words leave in issue order; no reordering.
- cfg_valid_i outside IDLE is ignored (cfg_ready_o=0).

Optional Feature:
Macro SNAX_READER_STALL_CNT_EN.
- Defined: stall_cycles_o counts cycles with tcdm_q_valid_o && !tcdm_q_ready_i. It clears on reset and on descriptor acceptance, and saturates at 2^32-1.
- Undefined: no counter logic; stall_cycles_o is tied to 0.

Test Plan:
- base=0x100, stride=4, len=4, q_ready=1, data_ready=1, bank returns addr-derived data -> requests at 0x100,0x104,0x108,0x10C on consecutive cycles; 4 data words in order; done_o pulses once; first data_valid_o appears 3 cycles after the first handshake.
- Same job with data_ready_i=0 throughout -> exactly 4 handshakes then q_valid stays 0 (FifoDepth=4 credits); FIFO full with no overflow; releasing data_ready drains all 4 words, then done_o.
- q_ready toggling 1,0,0,1 with len=3 -> address held stable during stall; stall_cycles_o=2 with macro defined, 0 without.
- len=0 -> no request issued; done_o one cycle after acceptance; cfg_ready_o stays 1.
- base=0xFFFF_FFFF_FFF8 (48-bit), stride=8, len=2 -> addresses 0xFFFF_FFFF_FFF8 then 0x0000_0000_0000 (wrap).
- rst_i asserted one cycle after 2 handshakes of a len=8 job -> all outputs at reset values next cycle; late bank data not captured; a new job runs cleanly.
